// File: rtl/td4_pkg.sv
// Shared types and default constants for the TD4 switch-input path.
package td4_pkg;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } db_state_t;

   localparam int TD4_SW_WIDTH    = 4;
   localparam int TD4_DB_TICK_DIV = 1000;
   localparam int TD4_DB_SAMPLES  = 4;

   // Debounce run counter needs to hold STABLE_SAMPLES-1 with headroom.
   function automatic int db_cnt_width(input int samples);
      return $clog2(samples) + 1;
   endfunction

   function automatic int div_cnt_width(input int tick_div);
      return (tick_div > 1) ? $clog2(tick_div) : 1;
   endfunction

endpackage

// File: rtl/td4_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-sampled debounce FSM, edge strobes.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   STABLE  | level matches the accepted switch value, waiting for a mismatch
//   PENDING | counting consecutive mismatching ticks before accepting a flip
module td4_debounce_bit
   import td4_pkg::*;
#(
   parameter int STABLE_SAMPLES = TD4_DB_SAMPLES
) (
   input  logic clock,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rise_next,
   output logic fall_next
);

   localparam int CW = db_cnt_width(STABLE_SAMPLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   db_state_t     state;
   db_state_t     state_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          level_next;
   logic          mismatch;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   assign mismatch = (sync_q2 != level);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= STABLE;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         level <= level_next;
         rise  <= rise_next;
         fall  <= fall_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      level_next = level;
      case (state)
         STABLE: begin
            if (tick && mismatch) begin
               cnt_next = CNT_ONE;
               if (STABLE_SAMPLES == 1) begin
                  level_next = ~level;
               end else begin
                  state_next = PENDING;
               end
            end
         end
         PENDING: begin
            if (tick) begin
               if (!mismatch) begin
                  cnt_next   = '0;
                  state_next = STABLE;
               end else if (cnt == CNT_LAST) begin
                  level_next = ~level;
                  cnt_next   = '0;
                  state_next = STABLE;
               end else begin
                  cnt_next = cnt + CNT_ONE;
               end
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = STABLE;
         end
      endcase
   end

   // Exported so the top can register a combined change strobe in the same cycle.
   assign rise_next = level_next & ~level;
   assign fall_next = ~level_next & level;

endmodule

// File: rtl/td4_sw_input.sv
// TD4 switch-input conditioner: shared sample-tick prescaler plus one debouncer per bit.
module td4_sw_input
   import td4_pkg::*;
#(
   parameter int WIDTH          = TD4_SW_WIDTH,
   parameter int TICK_DIV       = TD4_DB_TICK_DIV,
   parameter int STABLE_SAMPLES = TD4_DB_SAMPLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed,
   output logic             tick
);

   localparam int DW = div_cnt_width(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   logic [DW-1:0]    div_cnt;
   logic [WIDTH-1:0] rise_next;
   logic [WIDTH-1:0] fall_next;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   // Gated so tick reads 0 during reset even when TICK_DIV is 1.
   assign tick = (div_cnt == DIV_LAST) & ~reset;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      td4_debounce_bit #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_db (
         .clock    (clock),
         .reset    (reset),
         .tick     (tick),
         .raw      (sw_raw[i]),
         .level    (sw_out[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .rise_next(rise_next[i]),
         .fall_next(fall_next[i])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         changed <= 1'b0;
      end else begin
         changed <= |(rise_next | fall_next);
      end
   end

endmodule
